ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register and execute-operand selection stage of the RV32I core; sits directly upstream of the ALU. It captures decoded operands and control each cycle, resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and detects load-use hazards by stalling decode for one cycle. It drives the ALU operand inputs and ALU control.

## Interface
- No parameters; data width fixed at 32, register address width fixed at 5.
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- id_valid_i  in  1  decode slot holds a real instruction
- id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  in  32 each  decoded values
- id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  5 each  register indices
- id_src_a_sel_i  in  1  0: rs1, 1: PC
- id_src_b_sel_i  in  1  0: rs2, 1: immediate
- id_alu_control_i  in  3  ALU opcode (000 ADD … 110 SRL)
- id_reg_write_i, id_mem_read_i, id_mem_write_i  in  1 each  control flags
- flush_i  in  1  taken branch/jump; kill instruction entering EX
- mem_reg_write_i  in  1, mem_rd_addr_i  in  5, mem_result_i  in  32  EX/MEM forward source
- wb_reg_write_i  in  1, wb_rd_addr_i  in  5, wb_result_i  in  32  MEM/WB forward source
- src_a_o, src_b_o  out  32  ALU operands
- alu_control_o  out  3  registered ALU opcode
- store_data_o  out  32  forwarded rs2 value for stores
- ex_rd_addr_o  out  5; ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_valid_o  out  1 each
- stall_o  out  1  hold PC and IF/ID this cycle
- stall_count_o  out  32  saturating count of load-use stall cycles

## Operation
- Register bank (ex_*): pc, rs1_data, rs2_data, imm, rs1/rs2/rd addr, src sels, alu_control, reg_write, mem_read, mem_write, valid.
- Per edge, priority: rst_i > flush_i > stall_o > normal.
  - flush_i or stall_o: ex_valid <= 0, other fields don't-care but control flags cleared to 0 (bubble).
  - normal: all fields <= id_*, ex_valid <= id_valid_i.
- Control outputs qualified: ex_reg_write_o, ex_mem_read_o, ex_mem_write_o = registered flag AND ex_valid.
- Load-use detect (combinational): stall_o = id_valid_i & ex_valid & ex_mem_read & ex_rd != 0 & (ex_rd == id_rs1_addr_i | ex_rd == id_rs2_addr_i). Both sources compared regardless of use (conservative).
- stall_o is suppressed when flush_i is high.
- Forwarding, per operand rsN (combinational, uses registered ex_rsN):
  - mem_reg_write_i & mem_rd_addr_i != 0 & mem_rd_addr_i == ex_rsN -> mem_result_i;
  - else wb_reg_write_i & wb_rd_addr_i != 0 & wb_rd_addr_i == ex_rsN -> wb_result_i;
  - else ex_rsN_data. MEM has priority over WB. x0 never forwarded.
- src_a_o = ex_src_a_sel ? ex_pc : fwd_rs1; src_b_o = ex_src_b_sel ? ex_imm : fwd_rs2; store_data_o = fwd_rs2 always.
- stall_count_o increments by 1 on each edge where stall_o=1; saturates at 32'hFFFF_FFFF.

## Timing
- Reset (async, immediate): all registers 0; ex_valid_o=0, alu_control_o=000, ex_rd_addr_o=0, all control outputs 0, stall_count_o=0; src_a_o=src_b_o=store_data_o=0 unless forwarding inputs hit (cannot, ex_rs=0).
- Latency: ID inputs appear on outputs one cycle after capture edge; forwarding is zero-latency (same cycle as mem/wb inputs).
- Load-use: one bubble exactly; next cycle ex_mem_read cleared so stall_o drops, decode instruction captured on that edge.
- Simultaneous flush_i and load-use: flush wins, no stall, stall_count unchanged.
- Reset mid-stall: stall_o deasserts immediately (ex_valid=0).

## Test plan
- Reset: assert rst_i mid-run -> all outputs 0, stall_count_o=0, asynchronously before next edge.
- Plain ADD: rs1=5, rs2=7 data, sels 0, alu_control 000 -> next cycle src_a_o=5, src_b_o=7, alu_control_o=000, ex_valid_o=1.
- Forward priority: ex_rs1=3; mem_rd=3 result 0x11, wb_rd=3 result 0x22 -> src_a_o=0x11; drop mem_reg_write_i -> 0x22; set rd=0 on both -> register value.
- Load-use: LW x4 in EX, decode ADD x5,x4,x1 -> stall_o=1 one cycle, ex_valid_o=0 next cycle, ADD captured following edge, stall_count_o=1.
- Flush: flush_i=1 with id_valid_i=1, id_reg_write_i=1 -> next cycle ex_valid_o=0, ex_reg_write_o=0; flush during load-use -> stall_o=0.
- Immediate/PC select: src_a_sel=1, pc=0x100, src_b_sel=1, imm=0xFFFF_FFFC -> src_a_o=0x100, src_b_o=0xFFFF_FFFC, store_data_o=forwarded rs2.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with load-use stall and EX/MEM, MEM/WB operand forwarding
module ex_operand_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_src_a_sel_i,
  input  logic        id_src_b_sel_i,
  input  logic [2:0]  id_alu_control_i,
  input  logic        id_reg_write_i,
  input  logic        id_mem_read_i,
  input  logic        id_mem_write_i,
  input  logic        flush_i,
  input  logic        mem_reg_write_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic [31:0] mem_result_i,
  input  logic        wb_reg_write_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic [31:0] wb_result_i,
  output logic [31:0] src_a_o,
  output logic [31:0] src_b_o,
  output logic [2:0]  alu_control_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  ex_rd_addr_o,
  output logic        ex_reg_write_o,
  output logic        ex_mem_read_o,
  output logic        ex_mem_write_o,
  output logic        ex_valid_o,
  output logic        stall_o,
  output logic [31:0] stall_count_o
);
  logic [31:0] pc_q, rs1_data_q, rs2_data_q, imm_q, stall_count_q, stall_count_d;
  logic [4:0]  rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [2:0]  alu_control_q;
  logic        src_a_sel_q, src_b_sel_q, reg_write_q, mem_read_q, mem_write_q, valid_q;
  logic        reg_write_d, mem_read_d, mem_write_d, valid_d, bubble;
  logic [31:0] fwd_rs1, fwd_rs2;
  always_comb begin
    stall_o = ~flush_i & id_valid_i & valid_q & mem_read_q & (rd_addr_q != 5'd0) &
              ((rd_addr_q == id_rs1_addr_i) | (rd_addr_q == id_rs2_addr_i));
    bubble = flush_i | stall_o;
    valid_d = ~bubble & id_valid_i;
    reg_write_d = ~bubble & id_reg_write_i;
    mem_read_d = ~bubble & id_mem_read_i;
    mem_write_d = ~bubble & id_mem_write_i;
    stall_count_d = (stall_o && stall_count_q != 32'hFFFF_FFFF) ? stall_count_q + 32'd1 : stall_count_q;
    fwd_rs1 = (mem_reg_write_i && mem_rd_addr_i != 5'd0 && mem_rd_addr_i == rs1_addr_q) ? mem_result_i :
              (wb_reg_write_i && wb_rd_addr_i != 5'd0 && wb_rd_addr_i == rs1_addr_q) ? wb_result_i : rs1_data_q;
    fwd_rs2 = (mem_reg_write_i && mem_rd_addr_i != 5'd0 && mem_rd_addr_i == rs2_addr_q) ? mem_result_i :
              (wb_reg_write_i && wb_rd_addr_i != 5'd0 && wb_rd_addr_i == rs2_addr_q) ? wb_result_i : rs2_data_q;
    src_a_o = src_a_sel_q ? pc_q : fwd_rs1;
    src_b_o = src_b_sel_q ? imm_q : fwd_rs2;
    store_data_o = fwd_rs2;
    alu_control_o = alu_control_q;
    ex_rd_addr_o = rd_addr_q;
    ex_valid_o = valid_q;
    ex_reg_write_o = reg_write_q & valid_q;
    ex_mem_read_o = mem_read_q & valid_q;
    ex_mem_write_o = mem_write_q & valid_q;
    stall_count_o = stall_count_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q <= '0;
      src_a_sel_q <= 1'b0;
      src_b_sel_q <= 1'b0;
      alu_control_q <= '0;
      reg_write_q <= 1'b0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      pc_q <= id_pc_i;
      rs1_data_q <= id_rs1_data_i;
      rs2_data_q <= id_rs2_data_i;
      imm_q <= id_imm_i;
      rs1_addr_q <= id_rs1_addr_i;
      rs2_addr_q <= id_rs2_addr_i;
      rd_addr_q <= id_rd_addr_i;
      src_a_sel_q <= id_src_a_sel_i;
      src_b_sel_q <= id_src_b_sel_i;
      alu_control_q <= id_alu_control_i;
      reg_write_q <= reg_write_d;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      valid_q <= valid_d;
      stall_count_q <= stall_count_d;
    end
  end
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        id_valid_i, id_src_a_sel_i, id_src_b_sel_i, id_reg_write_i, id_mem_read_i, id_mem_write_i;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [2:0]  id_alu_control_i;
  logic        flush_i, mem_reg_write_i, wb_reg_write_i;
  logic [4:0]  mem_rd_addr_i, wb_rd_addr_i;
  logic [31:0] mem_result_i, wb_result_i;
  logic [31:0] src_a_o, src_b_o, store_data_o, stall_count_o;
  logic [2:0]  alu_control_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_valid_o, stall_o;
  int n_checks = 0;
  int n_fail = 0;
  ex_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_src_a_sel_i(id_src_a_sel_i), .id_src_b_sel_i(id_src_b_sel_i), .id_alu_control_i(id_alu_control_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .flush_i(flush_i), .mem_reg_write_i(mem_reg_write_i), .mem_rd_addr_i(mem_rd_addr_i),
    .mem_result_i(mem_result_i), .wb_reg_write_i(wb_reg_write_i), .wb_rd_addr_i(wb_rd_addr_i),
    .wb_result_i(wb_result_i), .src_a_o(src_a_o), .src_b_o(src_b_o), .alu_control_o(alu_control_o),
    .store_data_o(store_data_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o), .ex_valid_o(ex_valid_o),
    .stall_o(stall_o), .stall_count_o(stall_count_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic idle();
    id_valid_i = 0; id_pc_i = 0; id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0; id_src_a_sel_i = 0; id_src_b_sel_i = 0;
    id_alu_control_i = 0; id_reg_write_i = 0; id_mem_read_i = 0; id_mem_write_i = 0; flush_i = 0;
    mem_reg_write_i = 0; mem_rd_addr_i = 0; mem_result_i = 0;
    wb_reg_write_i = 0; wb_rd_addr_i = 0; wb_result_i = 0;
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic load_lw_x4();
    idle();
    id_valid_i = 1; id_mem_read_i = 1; id_reg_write_i = 1; id_rd_addr_i = 4; id_rs1_addr_i = 1;
    tick();
    idle();
    id_valid_i = 1; id_reg_write_i = 1; id_rs1_addr_i = 4; id_rs2_addr_i = 1; id_rd_addr_i = 5;
    id_rs1_data_i = 32'hA; id_rs2_data_i = 32'hB;
  endtask
  task automatic test_reset();
    idle();
    tick();
    n_checks++; if ({src_a_o, src_b_o, store_data_o, stall_count_o, alu_control_o, ex_rd_addr_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_valid_o, stall_o} !== '0) begin n_fail++; $display("FAIL reset_init: outputs not all zero, valid=%b count=%0d", ex_valid_o, stall_count_o); end
    rst_i = 0;
    id_valid_i = 1; id_rs1_data_i = 9; id_rs2_data_i = 8; id_rd_addr_i = 7; id_alu_control_i = 3'b101;
    id_reg_write_i = 1; id_mem_write_i = 1;
    tick();
    n_checks++; if (ex_valid_o !== 1'b1 || src_a_o !== 32'd9 || ex_mem_write_o !== 1'b1) begin n_fail++; $display("FAIL reset_preload: valid=%b src_a=%h memw=%b, wanted 1 9 1", ex_valid_o, src_a_o, ex_mem_write_o); end
    #2 rst_i = 1;
    #1;
    n_checks++; if ({src_a_o, src_b_o, store_data_o, stall_count_o, alu_control_o, ex_rd_addr_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_valid_o, stall_o} !== '0) begin n_fail++; $display("FAIL reset_async: src_a=%h valid=%b alu=%b rd=%0d, wanted all zero", src_a_o, ex_valid_o, alu_control_o, ex_rd_addr_o); end
    idle();
    tick();
    rst_i = 0;
  endtask
  task automatic test_add();
    idle();
    id_valid_i = 1; id_rs1_data_i = 5; id_rs2_data_i = 7; id_rs1_addr_i = 1; id_rs2_addr_i = 2;
    id_rd_addr_i = 3; id_reg_write_i = 1; id_alu_control_i = 3'b000;
    tick();
    n_checks++; if (src_a_o !== 32'd5 || src_b_o !== 32'd7) begin n_fail++; $display("FAIL add_operands: got %h %h, wanted 5 7", src_a_o, src_b_o); end
    n_checks++; if (alu_control_o !== 3'b000 || ex_valid_o !== 1'b1 || ex_rd_addr_o !== 5'd3 || ex_reg_write_o !== 1'b1) begin n_fail++; $display("FAIL add_ctrl: alu=%b valid=%b rd=%0d rw=%b, wanted 000 1 3 1", alu_control_o, ex_valid_o, ex_rd_addr_o, ex_reg_write_o); end
    idle();
    id_valid_i = 1; id_alu_control_i = 3'b110; id_mem_write_i = 1;
    tick();
    n_checks++; if (alu_control_o !== 3'b110 || ex_mem_write_o !== 1'b1 || ex_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL add_next: alu=%b memw=%b rw=%b, wanted 110 1 0", alu_control_o, ex_mem_write_o, ex_reg_write_o); end
  endtask
  task automatic test_forward();
    idle();
    id_valid_i = 1; id_rs1_addr_i = 3; id_rs1_data_i = 32'h33; id_rs2_addr_i = 4; id_rs2_data_i = 32'h44;
    tick();
    mem_reg_write_i = 1; mem_rd_addr_i = 3; mem_result_i = 32'h11;
    wb_reg_write_i = 1; wb_rd_addr_i = 3; wb_result_i = 32'h22;
    #1;
    n_checks++; if (src_a_o !== 32'h11) begin n_fail++; $display("FAIL fwd_mem_priority: got %h, wanted 11", src_a_o); end
    mem_reg_write_i = 0;
    #1;
    n_checks++; if (src_a_o !== 32'h22) begin n_fail++; $display("FAIL fwd_wb: got %h, wanted 22", src_a_o); end
    mem_reg_write_i = 1; mem_rd_addr_i = 0; wb_rd_addr_i = 0;
    #1;
    n_checks++; if (src_a_o !== 32'h33 || src_b_o !== 32'h44) begin n_fail++; $display("FAIL fwd_x0: got %h %h, wanted 33 44", src_a_o, src_b_o); end
    wb_rd_addr_i = 4;
    #1;
    n_checks++; if (src_b_o !== 32'h22 || store_data_o !== 32'h22 || src_a_o !== 32'h33) begin n_fail++; $display("FAIL fwd_rs2: b=%h st=%h a=%h, wanted 22 22 33", src_b_o, store_data_o, src_a_o); end
    mem_rd_addr_i = 4;
    #1;
    n_checks++; if (src_b_o !== 32'h11) begin n_fail++; $display("FAIL fwd_rs2_mem: got %h, wanted 11", src_b_o); end
  endtask
  task automatic test_load_use();
    load_lw_x4();
    #1;
    n_checks++; if (stall_o !== 1'b1 || ex_mem_read_o !== 1'b1) begin n_fail++; $display("FAIL lu_stall: stall=%b memr=%b, wanted 1 1", stall_o, ex_mem_read_o); end
    tick();
    n_checks++; if (ex_valid_o !== 1'b0 || stall_o !== 1'b0 || ex_mem_read_o !== 1'b0 || ex_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: valid=%b stall=%b memr=%b rw=%b, wanted 0 0 0 0", ex_valid_o, stall_o, ex_mem_read_o, ex_reg_write_o); end
    n_checks++; if (stall_count_o !== 32'd1) begin n_fail++; $display("FAIL lu_count: got %0d, wanted 1", stall_count_o); end
    tick();
    n_checks++; if (ex_valid_o !== 1'b1 || ex_rd_addr_o !== 5'd5 || src_a_o !== 32'hA || src_b_o !== 32'hB || stall_count_o !== 32'd1) begin n_fail++; $display("FAIL lu_capture: valid=%b rd=%0d a=%h b=%h cnt=%0d, wanted 1 5 a b 1", ex_valid_o, ex_rd_addr_o, src_a_o, src_b_o, stall_count_o); end
  endtask
  task automatic test_flush();
    idle();
    id_valid_i = 1; id_reg_write_i = 1; id_rd_addr_i = 9; flush_i = 1;
    tick();
    flush_i = 0;
    n_checks++; if (ex_valid_o !== 1'b0 || ex_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: valid=%b rw=%b, wanted 0 0", ex_valid_o, ex_reg_write_o); end
    load_lw_x4();
    flush_i = 1;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_vs_lu: stall=%b, wanted 0", stall_o); end
    tick();
    flush_i = 0;
    n_checks++; if (stall_count_o !== 32'd1 || ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_count: cnt=%0d valid=%b, wanted 1 0", stall_count_o, ex_valid_o); end
  endtask
  task automatic test_select();
    idle();
    id_valid_i = 1; id_src_a_sel_i = 1; id_pc_i = 32'h100; id_src_b_sel_i = 1; id_imm_i = 32'hFFFF_FFFC;
    id_rs1_data_i = 32'h55; id_rs2_addr_i = 6; id_rs2_data_i = 32'h66;
    tick();
    n_checks++; if (src_a_o !== 32'h100 || src_b_o !== 32'hFFFF_FFFC || store_data_o !== 32'h66) begin n_fail++; $display("FAIL sel_basic: a=%h b=%h st=%h, wanted 100 fffffffc 66", src_a_o, src_b_o, store_data_o); end
    wb_reg_write_i = 1; wb_rd_addr_i = 6; wb_result_i = 32'h77;
    #1;
    n_checks++; if (store_data_o !== 32'h77 || src_b_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL sel_fwd_store: st=%h b=%h, wanted 77 fffffffc", store_data_o, src_b_o); end
  endtask
  task automatic test_reset_mid_stall();
    load_lw_x4();
    #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_stall_pre: stall=%b, wanted 1", stall_o); end
    rst_i = 1;
    #1;
    n_checks++; if (stall_o !== 1'b0 || ex_valid_o !== 1'b0 || stall_count_o !== 32'd0) begin n_fail++; $display("FAIL rst_stall: stall=%b valid=%b cnt=%0d, wanted 0 0 0", stall_o, ex_valid_o, stall_count_o); end
    idle();
    tick();
    rst_i = 0;
  endtask
  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_flush();
    test_select();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
